// File: rtl/exe_stage_pkg.sv
// ============================================================================
// exe_stage_pkg : shared encodings for the execute stage (ALU commands,
//                 shifter types, NZCV flag positions). Rev 1.0
// ============================================================================
`default_nettype none

package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

endpackage

`default_nettype wire

// File: rtl/exe_alu.sv
// ============================================================================
// exe_alu : combinational ALU producing a result and NZCV flags. Rev 1.0
// ============================================================================
`default_nettype none

module exe_alu
  import exe_stage_pkg::*;
(
  input  logic [3:0]  cmd,
  input  logic [31:0] rn,
  input  logic [31:0] val2,
  input  logic [3:0]  status_in,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [31:0] op_b;
  logic        cin;
  logic [32:0] sum;
  logic        ovf;
  logic        c_out;
  logic        v_out;
  logic        known;

  // Subtraction is Rn + ~Val2 + cin, so the adder carry is already NOT-borrow.
  always_comb begin
    op_b = val2;
    cin  = 1'b0;
    case (exe_cmd_e'(cmd))
      CMD_ADC: cin = status_in[FLAG_C];
      CMD_SUB: begin op_b = ~val2; cin = 1'b1; end
      CMD_SBC: begin op_b = ~val2; cin = status_in[FLAG_C]; end
      default: ;
    endcase
    sum = {1'b0, rn} + {1'b0, op_b} + {32'b0, cin};
    ovf = (rn[31] == op_b[31]) && (sum[31] != rn[31]);
  end

  always_comb begin
    result = 32'b0;
    c_out  = status_in[FLAG_C];
    v_out  = status_in[FLAG_V];
    known  = 1'b1;
    case (exe_cmd_e'(cmd))
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        result = sum[31:0];
        c_out  = sum[32];
        v_out  = ovf;
      end
      CMD_AND: result = rn & val2;
      CMD_ORR: result = rn | val2;
      CMD_EOR: result = rn ^ val2;
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    flags = status_in;
    if (known) begin
      flags[FLAG_N] = result[31];
      flags[FLAG_Z] = (result == 32'b0);
      flags[FLAG_C] = c_out;
      flags[FLAG_V] = v_out;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
// exe_stage : Val2 generator, ALU, branch target, status and EXE/MEM
//             registers of the pipelined ARM core. Rev 1.0
// ============================================================================
`default_nettype none

module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] val_Rn_in,
  input  logic [31:0] val_Rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  status_in,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status,
  output logic        wb_en,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] alu_res,
  output logic [31:0] val_Rm,
  output logic [3:0]  dest
);

  logic [31:0] w_val2;
  logic [31:0] w_alu_res;
  logic [3:0]  w_alu_flags;
  logic [4:0]  w_shamt;

  assign w_shamt = shift_operand_in[11:7];

  // Memory addressing takes the raw 12-bit offset even when imm_in is set.
  always_comb begin
    w_val2 = val_Rm_in;
    if (mem_read_en_in || mem_write_en_in) begin
      w_val2 = {20'b0, shift_operand_in};
    end else if (imm_in) begin
      w_val2 = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
    end else begin
      case (shift_e'(shift_operand_in[6:5]))
        SH_LSL: w_val2 = val_Rm_in << w_shamt;
        SH_LSR: w_val2 = val_Rm_in >> w_shamt;
        SH_ASR: w_val2 = $unsigned($signed(val_Rm_in) >>> w_shamt);
        SH_ROR: w_val2 = ror32(val_Rm_in, w_shamt);
        default: w_val2 = val_Rm_in;
      endcase
    end
  end

  exe_alu u_alu (
    .cmd       (exe_cmd_in),
    .rn        (val_Rn_in),
    .val2      (w_val2),
    .status_in (status_in),
    .result    (w_alu_res),
    .flags     (w_alu_flags)
  );

  assign branch_taken = B_in;
  assign branch_addr  = PC_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= 4'b0;
    end else if (!freeze && S_in) begin
      status <= w_alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en        <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      alu_res      <= 32'b0;
      val_Rm       <= 32'b0;
      dest         <= 4'b0;
    end else if (!freeze) begin
      wb_en        <= wb_en_in;
      mem_read_en  <= mem_read_en_in;
      mem_write_en <= mem_write_en_in;
      alu_res      <= w_alu_res;
      val_Rm       <= val_Rm_in;
      dest         <= dest_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ============================================================================
// tb_exe_stage : scoreboard bench for exe_stage with an independent model.
// ============================================================================
`default_nettype none

module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, wb_en_in, mem_read_en_in, mem_write_en_in, B_in, S_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, status_in;
  logic [31:0] PC_in, val_Rn_in, val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        branch_taken, wb_en, mem_read_en, mem_write_en;
  logic [31:0] branch_addr, alu_res, val_Rm;
  logic [3:0]  status, dest;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .wb_en_in(wb_en_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .B_in(B_in), .S_in(S_in), .exe_cmd_in(exe_cmd_in), .PC_in(PC_in),
    .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .status_in(status_in), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .status(status), .wb_en(wb_en),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .alu_res(alu_res),
    .val_Rm(val_Rm), .dest(dest)
  );

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic        wb;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_val2();
    logic [31:0] v;
    int          n;
    if (mem_read_en_in || mem_write_en_in) return {20'b0, shift_operand_in};
    if (imm_in) begin
      v = {24'b0, shift_operand_in[7:0]};
      n = 2 * int'(shift_operand_in[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      return v;
    end
    v = val_Rm_in;
    n = int'(shift_operand_in[11:7]);
    for (int i = 0; i < n; i++) begin
      case (shift_operand_in[6:5])
        2'b00: v = {v[30:0], 1'b0};
        2'b01: v = {1'b0, v[31:1]};
        2'b10: v = {v[31], v[31:1]};
        default: v = {v[0], v[31:1]};
      endcase
    end
    return v;
  endfunction

  // Reference ALU built on 64-bit signed/unsigned arithmetic.
  task automatic model_alu(output logic [31:0] res, output logic [3:0] fl);
    logic [31:0] b;
    longint      sa, sb, full;
    longint unsigned ua, ub, cin;
    logic        c, v, known;
    b  = model_val2();
    sa = longint'($signed(val_Rn_in)); sb = longint'($signed(b));
    ua = {32'b0, val_Rn_in};           ub = {32'b0, b};
    cin = {63'b0, status_in[1]};
    c = status_in[1]; v = status_in[0]; known = 1'b1; res = 32'b0;
    case (exe_cmd_in)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        if (exe_cmd_in == 4'd2) cin = 0;
        full = sa + sb + longint'(cin);
        res  = val_Rn_in + b + cin[31:0];
        c    = (ua + ub + cin) > 64'hFFFF_FFFF;
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        if (exe_cmd_in == 4'd4) cin = 1;
        full = sa - sb - (1 - longint'(cin));
        res  = val_Rn_in - b - (32'd1 - cin[31:0]);
        c    = ua >= ub + (1 - cin);
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd6: res = val_Rn_in & b;
      4'd7: res = val_Rn_in | b;
      4'd8: res = val_Rn_in ^ b;
      default: known = 1'b0;
    endcase
    fl = known ? {res[31], res == 32'b0, c, v} : status_in;
  endtask

  // Predict, clock once, then compare everything against the popped entry.
  task automatic cycle();
    exp_t        e;
    exp_t        got;
    logic [31:0] r;
    logic [3:0]  f;
    #1;
    check("branch_taken", {31'b0, branch_taken}, {31'b0, B_in});
    check("branch_addr", branch_addr, PC_in + 32'(int'($signed({signed_imm_24_in, 2'b00}))));
    model_alu(r, f);
    e = cur_exp;
    if (rst) e = '0;
    else if (!freeze) begin
      e.alu_res = r; e.val_rm = val_Rm_in; e.dest = dest_in;
      e.wb = wb_en_in; e.mr = mem_read_en_in; e.mw = mem_write_en_in;
      if (S_in) e.status = f;
    end
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    cur_exp = e;
    got = '{alu_res, val_Rm, dest, status, wb_en, mem_read_en, mem_write_en};
    check("alu_res", got.alu_res, e.alu_res);
    check("val_Rm", got.val_rm, e.val_rm);
    check("dest", {28'b0, got.dest}, {28'b0, e.dest});
    check("status", {28'b0, got.status}, {28'b0, e.status});
    check("ctrl", {29'b0, got.wb, got.mr, got.mw}, {29'b0, e.wb, e.mr, e.mw});
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                        input logic [31:0] rm, input logic im, input logic [11:0] so);
    exe_cmd_in = cmd; S_in = s; val_Rn_in = rn; val_Rm_in = rm; imm_in = im;
    shift_operand_in = so; wb_en_in = 1'b1; mem_read_en_in = 1'b0;
    mem_write_en_in = 1'b0; B_in = 1'b0; freeze = 1'b0; rst = 1'b0;
  endtask

  initial begin
    cur_exp = '0;
    rst = 1'b1; freeze = 1'b0; wb_en_in = 1'b1; mem_read_en_in = 1'b1; mem_write_en_in = 1'b1;
    B_in = 1'b0; S_in = 1'b1; imm_in = 1'b0; exe_cmd_in = 4'd2; PC_in = 32'h100;
    val_Rn_in = 32'h1234; val_Rm_in = 32'h55; shift_operand_in = 12'h0;
    signed_imm_24_in = 24'h3; dest_in = 4'd7; status_in = 4'hF;
    cycle();
    check("reset_alu_res", alu_res, 32'h0);
    check("reset_status", {28'b0, status}, 32'h0);

    set_op(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 12'h000); status_in = 4'b0000;
    cycle();
    check("adds_res", alu_res, 32'h8000_0000);
    check("adds_nzcv", {28'b0, status}, 32'b1001);

    set_op(4'd4, 1'b1, 32'd5, 32'd5, 1'b0, 12'h000);
    cycle();
    check("subs_res", alu_res, 32'h0);
    check("subs_nzcv", {28'b0, status}, 32'b0110);
    set_op(4'd4, 1'b0, 32'd9, 32'd3, 1'b0, 12'h000);
    cycle();
    check("sub_nos_res", alu_res, 32'd6);
    check("sub_nos_hold", {28'b0, status}, 32'b0110);

    set_op(4'd1, 1'b0, 32'h0, 32'h0, 1'b1, 12'h4FF);
    cycle();
    check("imm_rot8", alu_res, 32'hFF00_0000);
    set_op(4'd1, 1'b0, 32'h0, 32'h8000_0000, 1'b0, {5'd4, 2'b10, 5'b0});
    cycle();
    check("asr4", alu_res, 32'hF800_0000);

    set_op(4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h0);
    B_in = 1'b1; wb_en_in = 1'b0; PC_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
    #1;
    check("b_taken", {31'b0, branch_taken}, 32'd1);
    check("b_addr", branch_addr, 32'h0000_00F8);
    cycle();

    set_op(4'd2, 1'b0, 32'h400, 32'hDEAD, 1'b1, 12'h804);
    mem_read_en_in = 1'b1; signed_imm_24_in = 24'h10;
    cycle();
    check("ldr_addr", alu_res, 32'h0000_0C04);
    check("ldr_mr", {31'b0, mem_read_en}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      set_op(4'(2 + i), 1'b1, $urandom, $urandom, 1'b0, 12'(i * 37));
      freeze = 1'b1; dest_in = 4'(i + 9); status_in = 4'(i);
      cycle();
      check("frz_hold", alu_res, 32'h0000_0C04);
    end
    rst = 1'b1;
    cycle();
    check("rst_over_frz", {alu_res | val_Rm, 28'b0, dest | status},
          {32'h0, 28'b0, 4'h0});

    for (int i = 0; i < 60; i++) begin
      set_op(4'($urandom_range(0, 15)), 1'($urandom), $urandom, $urandom,
             1'($urandom), 12'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        mem_read_en_in = 1'($urandom); mem_write_en_in = ~mem_read_en_in;
      end
      B_in = 1'($urandom); wb_en_in = 1'($urandom);
      freeze = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 19) == 0);
      dest_in = 4'($urandom); status_in = 4'($urandom);
      PC_in = $urandom; signed_imm_24_in = 24'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
